// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, compare, conditionally subtract.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The incoming remainder is always below the divisor, so its MSB is zero.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_i[WIDTH];

    assign shifted = {rem_i[WIDTH-1:0], bit_i};
    assign diff    = shifted - {1'b0, divisor_i};
    assign q_bit_o = (shifted >= {1'b0, divisor_i});
    assign rem_o   = q_bit_o ? diff : shifted;

endmodule

// File: rtl/div_seq_restoring.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional macro DIV_ZERO_FLAG_EN adds a fast zero-divisor path and the div_by_zero output.
module div_seq_restoring
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
   ,output logic             div_by_zero
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef DIV_ZERO_FLAG_EN
    logic             dbz_q, dbz_d;
`endif

    logic [WIDTH:0]   step_rem;
    logic             step_q_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q_bit)
    );

    // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
`ifdef DIV_ZERO_FLAG_EN
        dbz_d   = dbz_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = ST_BUSY;
`ifdef DIV_ZERO_FLAG_EN
                    dbz_d   = (divisor == '0);
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = {1'b0, dividend};
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_BUSY: begin
                rem_d = step_rem;
                quo_d = {quo_q[WIDTH-2:0], step_q_bit};
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
`ifdef DIV_ZERO_FLAG_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
`ifdef DIV_ZERO_FLAG_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    // in_ready is gated by rst_n so it reads low for the whole time reset is held.
    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q[WIDTH-1:0];
`ifdef DIV_ZERO_FLAG_EN
    assign div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_div_seq_restoring.sv
// Self-checking bench for div_seq_restoring (WIDTH=4), directed cases plus random operands.
module tb_div_seq_restoring;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
    logic         div_by_zero;
`endif

    int checks = 0;
    int errors = 0;

    div_seq_restoring #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV_ZERO_FLAG_EN
       ,.div_by_zero (div_by_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, zero divisor gives all ones / dividend.
    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? (1 << W) - 1 : a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic int ref_lat(input int b);
`ifdef DIV_ZERO_FLAG_EN
        if (b == 0) return 1;
`endif
        return W + 1;
    endfunction

    // Issue one division, scramble the operand inputs while busy, hold the result
    // for 'hold' cycles of backpressure, then complete the handshake.
    task automatic run_op(input string tag, input int a, input int b, input int hold,
                          input bit zero_scramble);
        int n;
        int eq;
        int er;
        eq = ref_q(a, b);
        er = ref_r(a, b);
        @(negedge clk);
        chk({tag, ".in_ready_before"}, in_ready, 1);
        in_valid = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(posedge clk);
        n = 1;
        #1;
        chk({tag, ".in_ready_after_accept"}, in_ready, 0);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            dividend = zero_scramble ? '0 : W'($urandom);
            divisor  = zero_scramble ? '0 : W'($urandom);
            @(posedge clk);
            n++;
            #1;
        end
        in_valid = 1'b0;
        chk({tag, ".latency"}, n, ref_lat(b));
        if (!out_valid) return;
        chk({tag, ".quotient"}, quotient, eq);
        chk({tag, ".remainder"}, remainder, er);
        chk({tag, ".in_ready_done"}, in_ready, 0);
`ifdef DIV_ZERO_FLAG_EN
        chk({tag, ".div_by_zero"}, div_by_zero, (b == 0) ? 1 : 0);
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"}, out_valid, 1);
            chk({tag, ".hold_quotient"}, quotient, eq);
            chk({tag, ".hold_remainder"}, remainder, er);
            chk({tag, ".hold_in_ready"}, in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".valid_after_hs"}, out_valid, 0);
        chk({tag, ".in_ready_after_hs"}, in_ready, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        chk("reset.in_ready", in_ready, 0);
        chk("reset.out_valid", out_valid, 0);
        chk("reset.quotient", quotient, 0);
        chk("reset.remainder", remainder, 0);
`ifdef DIV_ZERO_FLAG_EN
        chk("reset.div_by_zero", div_by_zero, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset.in_ready_first_clock", in_ready, 1);

        run_op("d13_4", 13, 4, 0, 1'b0);
        run_op("d15_1", 15, 1, 0, 1'b0);
        run_op("d2_7", 2, 7, 0, 1'b0);
        run_op("d9_0", 9, 0, 0, 1'b0);
        run_op("backpressure", 11, 5, 3, 1'b0);
        run_op("d10_3_scramble", 10, 3, 0, 1'b1);

        // Reset during the second BUSY step.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 4'd11;
        divisor  = 4'd2;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset.out_valid", out_valid, 0);
        chk("midreset.quotient", quotient, 0);
        chk("midreset.in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset.in_ready_first_clock", in_ready, 1);
        chk("midreset.no_result", out_valid, 0);
        run_op("d6_3_after_reset", 6, 3, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_op($sformatf("rand%0d", i), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
